// File: rtl/nonconsec_rep_checker.sv
// nonconsec_rep_checker
// Monitors "transmiter |-> ##1 recevier[=MIN_CNT:MAX_CNT]" over a bounded
// window. Each trigger claims a tracking slot. The slot counts recevier hits,
// which need not be consecutive, on the WINDOW edges after the trigger and
// then reports a one-cycle pass or fail pulse. Saturating totals of passes,
// fails and dropped triggers are exported.
module nonconsec_rep_checker #(
    parameter int MIN_CNT = 2,
    parameter int MAX_CNT = 5,
    parameter int WINDOW  = 8,
    parameter int SLOTS   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             transmiter,
    input  logic             recevier,
    output logic [SLOTS-1:0] pass_vec,
    output logic [SLOTS-1:0] fail_vec,
    output logic             overflow,
    output logic [SLOTS-1:0] busy_vec,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    // Age runs 0..WINDOW; hits saturate one past MAX_CNT, which is the
    // early-fail marker.
    localparam int AGE_W = $clog2(WINDOW + 1);
    localparam int HIT_W = $clog2(MAX_CNT + 2);

    localparam logic [AGE_W-1:0] AGE_END = AGE_W'(WINDOW);
    localparam logic [HIT_W-1:0] HIT_SAT = HIT_W'(MAX_CNT + 1);
    localparam logic [HIT_W-1:0] HIT_MIN = HIT_W'(MIN_CNT);

    // Per-slot state: one bit per slot, also driven out as busy_vec.
    localparam logic ST_FREE  = 1'b0;
    localparam logic ST_TRACK = 1'b1;

    logic [SLOTS-1:0] state_q;
    logic [SLOTS-1:0] state_d;
    logic [AGE_W-1:0] age_q [SLOTS];
    logic [AGE_W-1:0] age_d [SLOTS];
    logic [HIT_W-1:0] hit_q [SLOTS];
    logic [HIT_W-1:0] hit_d [SLOTS];

    logic [SLOTS-1:0] grant;
    logic             found;
    logic             drop;
    logic [SLOTS-1:0] pass_d;
    logic [SLOTS-1:0] fail_d;

    // Number of set bits in a verdict vector (SLOTS is at most 16).
    function automatic logic [4:0] popcount(input logic [SLOTS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < SLOTS; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    // Add a small increment to a statistics counter, clamping at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [4:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W + 1)'(inc);
        if (sum[CNT_W]) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    // Pick the lowest-index slot that is free at the start of this cycle;
    // a slot resolving on this edge is still seen as busy here.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (transmiter && !found && state_q[i] == ST_FREE) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        drop = transmiter && !found;
    end

    // Advance every tracking slot by one edge and decide its verdict; a free
    // slot that was granted starts a fresh attempt with the trigger-edge
    // recevier sample ignored.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            state_d[i] = state_q[i];
            age_d[i]   = age_q[i];
            hit_d[i]   = hit_q[i];
            pass_d[i]  = 1'b0;
            fail_d[i]  = 1'b0;
            if (state_q[i] == ST_TRACK) begin
                age_d[i] = age_q[i] + AGE_W'(1);
                if (recevier && hit_q[i] != HIT_SAT) begin
                    hit_d[i] = hit_q[i] + HIT_W'(1);
                end
                if (hit_d[i] == HIT_SAT) begin
                    fail_d[i]  = 1'b1;
                    state_d[i] = ST_FREE;
                end else if (age_d[i] == AGE_END) begin
                    if (hit_d[i] >= HIT_MIN) begin
                        pass_d[i] = 1'b1;
                    end else begin
                        fail_d[i] = 1'b1;
                    end
                    state_d[i] = ST_FREE;
                end
            end else if (grant[i]) begin
                state_d[i] = ST_TRACK;
                age_d[i]   = '0;
                hit_d[i]   = '0;
            end
        end
    end

    // Slot state, age and hit registers; reset discards in-flight attempts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                age_q[i] <= '0;
                hit_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < SLOTS; i++) begin
                age_q[i] <= age_d[i];
                hit_q[i] <= hit_d[i];
            end
        end
    end

    // Registered one-cycle verdict and overflow pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_vec <= '0;
            fail_vec <= '0;
            overflow <= 1'b0;
        end else begin
            pass_vec <= pass_d;
            fail_vec <= fail_d;
            overflow <= drop;
        end
    end

    // Saturating running totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            pass_cnt <= sat_add(pass_cnt, popcount(pass_d));
            fail_cnt <= sat_add(fail_cnt, popcount(fail_d));
            drop_cnt <= sat_add(drop_cnt, 5'(drop));
        end
    end

    assign busy_vec = state_q;

endmodule

// File: tb/tb_nonconsec_rep_checker.sv
// Testbench for nonconsec_rep_checker: directed scenarios plus a randomized
// run, all checked against an attempt-level reference model that counts
// recevier hits from a recorded history.
module tb_nonconsec_rep_checker;

    localparam int MIN_CNT = 2;
    localparam int MAX_CNT = 5;
    localparam int WINDOW  = 8;
    localparam int SLOTS   = 4;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             transmiter = 1'b0;
    logic             recevier = 1'b0;
    logic [SLOTS-1:0] pass_vec;
    logic [SLOTS-1:0] fail_vec;
    logic             overflow;
    logic [SLOTS-1:0] busy_vec;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] drop_cnt;

    nonconsec_rep_checker #(
        .MIN_CNT(MIN_CNT), .MAX_CNT(MAX_CNT), .WINDOW(WINDOW),
        .SLOTS(SLOTS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .transmiter(transmiter), .recevier(recevier),
        .pass_vec(pass_vec), .fail_vec(fail_vec), .overflow(overflow),
        .busy_vec(busy_vec), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: edge number, recevier history, and for each slot
    // whether an attempt occupies it and on which edge it was triggered.
    int               n = 0;
    bit               rx_hist [int];
    bit               att_on [SLOTS];
    int               att_t [SLOTS];
    logic [SLOTS-1:0] exp_pass, exp_fail, exp_busy;
    logic             exp_ovf;
    int               exp_pc, exp_fc, exp_dc;

    task automatic model_clear();
        for (int i = 0; i < SLOTS; i++) begin
            att_on[i] = 1'b0;
            att_t[i]  = 0;
        end
        exp_pass = '0; exp_fail = '0; exp_busy = '0; exp_ovf = 1'b0;
        exp_pc = 0; exp_fc = 0; exp_dc = 0;
    endtask

    task automatic reset_on();
        @(negedge clk);
        rst = 1'b1; transmiter = 1'b0; recevier = 1'b0;
        #1;
        model_clear();
    endtask

    task automatic reset_off();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one edge of stimulus and advance the model; returns #1 after the edge.
    task automatic apply(input bit tx, input bit rx);
        bit was_free [SLOTS];
        int h;
        bit found;
        @(negedge clk);
        transmiter = tx;
        recevier   = rx;
        @(posedge clk);
        n++;
        rx_hist[n] = rx;
        exp_pass = '0; exp_fail = '0; exp_ovf = 1'b0;
        for (int i = 0; i < SLOTS; i++) was_free[i] = !att_on[i];
        for (int i = 0; i < SLOTS; i++) begin
            if (att_on[i]) begin
                h = 0;
                for (int e = att_t[i] + 1; e <= n; e++) h += int'(rx_hist[e]);
                if (h == MAX_CNT + 1) begin
                    exp_fail[i] = 1'b1;
                    att_on[i]   = 1'b0;
                end else if (n - att_t[i] == WINDOW) begin
                    if (h >= MIN_CNT) exp_pass[i] = 1'b1;
                    else              exp_fail[i] = 1'b1;
                    att_on[i] = 1'b0;
                end
            end
        end
        if (tx) begin
            found = 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                if (!found && was_free[i]) begin
                    att_on[i] = 1'b1;
                    att_t[i]  = n;
                    found     = 1'b1;
                end
            end
            if (!found) begin
                exp_ovf = 1'b1;
                exp_dc  = (exp_dc + 1 > CNT_MAX) ? CNT_MAX : exp_dc + 1;
            end
        end
        exp_pc = (exp_pc + $countones(exp_pass) > CNT_MAX) ? CNT_MAX : exp_pc + $countones(exp_pass);
        exp_fc = (exp_fc + $countones(exp_fail) > CNT_MAX) ? CNT_MAX : exp_fc + $countones(exp_fail);
        for (int i = 0; i < SLOTS; i++) exp_busy[i] = att_on[i];
        #1;
    endtask

    task automatic test_reset();
        reset_on();
        vectors++;
        if ({pass_vec, fail_vec, busy_vec, overflow, pass_cnt, fail_cnt, drop_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset: outputs got %b/%b/%b/%b cnt %0d/%0d/%0d, want all 0",
                     pass_vec, fail_vec, busy_vec, overflow, pass_cnt, fail_cnt, drop_cnt);
        end
        reset_off();
    endtask

    // Run a stimulus table (bit j = edge j) against the model, checking every edge.
    task automatic run_table(input string name, input logic [15:0] tx_pat,
                             input logic [15:0] rx_pat, input int edges);
        for (int j = 0; j < edges; j++) begin
            apply(tx_pat[j], rx_pat[j]);
            vectors++;
            if ({pass_vec, fail_vec, busy_vec, overflow} !== {exp_pass, exp_fail, exp_busy, exp_ovf}) begin
                miscompares++;
                $display("FAIL %s edge %0d: pass/fail/busy/ovf got %b %b %b %b want %b %b %b %b",
                         name, j, pass_vec, fail_vec, busy_vec, overflow,
                         exp_pass, exp_fail, exp_busy, exp_ovf);
            end
            vectors++;
            if ({pass_cnt, fail_cnt, drop_cnt} !== {CNT_W'(exp_pc), CNT_W'(exp_fc), CNT_W'(exp_dc)}) begin
                miscompares++;
                $display("FAIL %s_cnt edge %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         name, j, pass_cnt, fail_cnt, drop_cnt, exp_pc, exp_fc, exp_dc);
            end
        end
    endtask

    task automatic test_pass();
        reset_on(); reset_off();
        run_table("pass", 16'h0001, 16'h0014, 9);
        vectors++;
        if (pass_vec !== 4'b0001 || fail_vec !== 4'b0000 || pass_cnt !== 5'd1) begin
            miscompares++;
            $display("FAIL pass_verdict: got pass %b fail %b cnt %0d want 0001 0000 1",
                     pass_vec, fail_vec, pass_cnt);
        end
    endtask

    task automatic test_fail_low();
        reset_on(); reset_off();
        run_table("fail_low", 16'h0001, 16'h0008, 9);
        vectors++;
        if (fail_vec !== 4'b0001 || pass_vec !== 4'b0000 || fail_cnt !== 5'd1) begin
            miscompares++;
            $display("FAIL fail_low_verdict: got fail %b pass %b cnt %0d want 0001 0000 1",
                     fail_vec, pass_vec, fail_cnt);
        end
    endtask

    task automatic test_early_fail();
        reset_on(); reset_off();
        run_table("early_fail", 16'h0001, 16'h007E, 7);
        vectors++;
        if (fail_vec !== 4'b0001 || busy_vec !== 4'b0000) begin
            miscompares++;
            $display("FAIL early_fail_verdict: got fail %b busy %b want 0001 0000", fail_vec, busy_vec);
        end
        run_table("early_fail_reuse", 16'h0001, 16'h0000, 1);
        vectors++;
        if (busy_vec !== 4'b0001 || fail_vec !== 4'b0000) begin
            miscompares++;
            $display("FAIL early_fail_reuse: got busy %b fail %b want 0001 0000", busy_vec, fail_vec);
        end
    endtask

    task automatic test_overflow();
        reset_on(); reset_off();
        run_table("overflow", 16'h001F, 16'h0000, 5);
        vectors++;
        if (overflow !== 1'b1 || busy_vec !== 4'b1111 || drop_cnt !== 5'd1) begin
            miscompares++;
            $display("FAIL overflow_pulse: got ovf %b busy %b drop %0d want 1 1111 1",
                     overflow, busy_vec, drop_cnt);
        end
        run_table("overflow_tail", 16'h0000, 16'h0000, 10);
    endtask

    task automatic test_hit_at_trigger();
        reset_on(); reset_off();
        run_table("trig_hit_a", 16'h0001, 16'h0003, 9);
        vectors++;
        if (fail_vec !== 4'b0001) begin
            miscompares++;
            $display("FAIL trig_hit_ignored: got fail %b want 0001", fail_vec);
        end
        run_table("trig_hit_b", 16'h0001, 16'h0006, 9);
        vectors++;
        if (pass_vec !== 4'b0001) begin
            miscompares++;
            $display("FAIL trig_hit_pass: got pass %b want 0001", pass_vec);
        end
    endtask

    task automatic test_reset_mid();
        reset_on(); reset_off();
        run_table("reset_mid_pre", 16'h0001, 16'h000E, 6);
        reset_on();
        vectors++;
        if ({pass_vec, fail_vec, busy_vec, overflow, pass_cnt, fail_cnt, drop_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: outputs got %b/%b/%b/%b cnt %0d/%0d/%0d, want all 0",
                     pass_vec, fail_vec, busy_vec, overflow, pass_cnt, fail_cnt, drop_cnt);
        end
        reset_off();
        run_table("reset_mid_idle", 16'h0000, 16'h0000, 10);
        run_table("reset_mid_fresh", 16'h0001, 16'h00A0, 9);
        vectors++;
        if (pass_vec !== 4'b0001 || pass_cnt !== 5'd1 || fail_cnt !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid_fresh: got pass %b pcnt %0d fcnt %0d want 0001 1 0",
                     pass_vec, pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_back_to_back();
        reset_on(); reset_off();
        run_table("b2b_a", 16'h030F, 16'h0000, 9);
        vectors++;
        if (fail_vec !== 4'b0001 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_freed_edge: got fail %b ovf %b want 0001 1", fail_vec, overflow);
        end
        run_table("b2b_b", 16'h0001, 16'h0000, 1);
        vectors++;
        if (fail_vec !== 4'b0010 || busy_vec !== 4'b1101 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_reclaim: got fail %b busy %b ovf %b want 0010 1101 0",
                     fail_vec, busy_vec, overflow);
        end
        run_table("b2b_tail", 16'h0000, 16'h0000, 10);
    endtask

    task automatic test_random();
        bit tx, rx;
        reset_on(); reset_off();
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) begin
                reset_on(); reset_off();
            end
            tx = ($urandom_range(0, 99) < 35);
            rx = ($urandom_range(0, 99) < 45);
            apply(tx, rx);
            vectors++;
            if ({pass_vec, fail_vec, busy_vec, overflow} !== {exp_pass, exp_fail, exp_busy, exp_ovf}) begin
                miscompares++;
                $display("FAIL random step %0d: pass/fail/busy/ovf got %b %b %b %b want %b %b %b %b",
                         k, pass_vec, fail_vec, busy_vec, overflow,
                         exp_pass, exp_fail, exp_busy, exp_ovf);
            end
            vectors++;
            if ({pass_cnt, fail_cnt, drop_cnt} !== {CNT_W'(exp_pc), CNT_W'(exp_fc), CNT_W'(exp_dc)}) begin
                miscompares++;
                $display("FAIL random_cnt step %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         k, pass_cnt, fail_cnt, drop_cnt, exp_pc, exp_fc, exp_dc);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_pass();
        test_fail_low();
        test_early_fail();
        test_overflow();
        test_hit_at_trigger();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
